// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the timer peripheral (slave).
interface apb_timer_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer: prescaled down-counter with one-shot/periodic modes,
// sticky expiry flag and a registered level interrupt.
module apb_timer_slave #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic                hclk,
  input  logic                hresetn,
  apb_timer_slave_if.slave    apb,
  output logic                irq
);

  logic             en_q, en_d;
  logic             periodic_q, periodic_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic [31:0]      prdata_q, prdata_d;

  logic             wr_acc, rd_setup;
  logic             wr_ctrl, wr_load, wr_pre, wr_status;
  logic             tick, expire;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{apb.paddr[31:5], apb.paddr[1:0], apb.pwdata};

  assign wr_acc    = apb.psel & apb.penable & apb.pwrite;
  assign rd_setup  = apb.psel & ~apb.penable & ~apb.pwrite;
  assign wr_ctrl   = wr_acc && (apb.paddr[4:2] == 3'd0);
  assign wr_load   = wr_acc && (apb.paddr[4:2] == 3'd1);
  assign wr_pre    = wr_acc && (apb.paddr[4:2] == 3'd3);
  assign wr_status = wr_acc && (apb.paddr[4:2] == 3'd4);

  assign tick   = en_q && (pre_cnt_q == pre_q);
  assign expire = tick && (value_q == '0);

  // Read mux samples current state, so a setup on an update edge sees the pre-update value.
  always_comb begin
    rd_data = '0;
    case (apb.paddr[4:2])
      3'd0:    rd_data[2:0]       = {irq_en_q, periodic_q, en_q};
      3'd1:    rd_data[CNT_W-1:0] = load_q;
      3'd2:    rd_data[CNT_W-1:0] = value_q;
      3'd3:    rd_data[PRE_W-1:0] = pre_q;
      3'd4:    rd_data[0]         = expired_q;
      default: rd_data            = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    load_d     = load_q;
    value_d    = value_q;
    pre_d      = pre_q;
    pre_cnt_d  = pre_cnt_q;
    expired_d  = expired_q;
    irq_d      = expired_q & irq_en_q;
    prdata_d   = rd_setup ? rd_data : prdata_q;

    if (en_q) pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

    if (tick) begin
      if (value_q != '0)   value_d = value_q - CNT_W'(1);
      else if (periodic_q) value_d = load_q;
      else                 en_d    = 1'b0;
    end

    // Expiry set beats a same-edge W1C.
    if (expire)                             expired_d = 1'b1;
    else if (wr_status && apb.pwdata[0])    expired_d = 1'b0;

    // Bus writes are applied last so they win over same-edge counter updates.
    if (wr_ctrl) begin
      en_d       = apb.pwdata[0];
      periodic_d = apb.pwdata[1];
      irq_en_d   = apb.pwdata[2];
      if (apb.pwdata[0] && !en_q) pre_cnt_d = '0;
    end
    if (wr_load) begin
      load_d    = apb.pwdata[CNT_W-1:0];
      value_d   = apb.pwdata[CNT_W-1:0];
      pre_cnt_d = '0;
    end
    if (wr_pre) begin
      pre_d     = apb.pwdata[PRE_W-1:0];
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      load_q     <= '0;
      value_q    <= '0;
      pre_q      <= '0;
      pre_cnt_q  <= '0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      load_q     <= load_d;
      value_q    <= value_d;
      pre_q      <= pre_d;
      pre_cnt_q  <= pre_cnt_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

  assign apb.prdata = prdata_q;
  assign irq        = irq_q;

endmodule
